// File: rtl/axis_biquad_cascade_filter_if.sv
// AXI4-Stream style handshake bundle (data, valid, ready) shared by the
// biquad cascade's input and output streams.
interface axis_biquad_cascade_filter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_biquad_cascade_filter.sv
// Cascade of direct-form-I biquad sections sharing one multiplier: five MACs
// plus one round/saturate/shift cycle per section, one sample in flight.
module axis_biquad_cascade_filter #(
  parameter int SIGNAL_WIDTH = 32,
  parameter int COEF_WIDTH   = 32,
  parameter int COEF_Q       = 28,
  parameter int NUM_SECTIONS = 4,
  parameter int CONFIG_ADDR  = 999
) (
  input  logic                          aclk,
  input  logic                          resetn,
  input  logic [31:0]                   config_addr,
  input  logic [511:0]                  config_data,
  axis_biquad_cascade_filter_if.slave   s_axis,
  axis_biquad_cascade_filter_if.master  m_axis,
  output logic                          sat_flag
);

  localparam int SW     = SIGNAL_WIDTH;
  localparam int CW     = COEF_WIDTH;
  localparam int PROD_W = SW + CW;
  localparam int ACC_W  = SW + CW + 3;
  localparam int SEC_W  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

  localparam logic [2:0]              TAP_UPDATE = 3'd5;
  localparam logic [SEC_W-1:0]        SEC_LAST   = SEC_W'(NUM_SECTIONS - 1);
  localparam logic signed [CW-1:0]    COEF_ONE   = {{(CW-1){1'b0}}, 1'b1} << COEF_Q;
  localparam logic signed [ACC_W-1:0] ROUND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_Q - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX      = {{(ACC_W-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN      = {{(ACC_W-SW+1){1'b1}}, {(SW-1){1'b0}}};
  localparam logic signed [SW-1:0]    SAT_POS    = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0]    SAT_NEG    = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;

  state_t state_q, state_d;

  logic [2:0]              tap_q;
  logic [SEC_W-1:0]        sec_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [SW-1:0]    x_cur_q;
  logic [SW-1:0]           tdata_q;
  logic                    bypass_q;

  logic signed [CW-1:0] b0_q [NUM_SECTIONS];
  logic signed [CW-1:0] b1_q [NUM_SECTIONS];
  logic signed [CW-1:0] b2_q [NUM_SECTIONS];
  logic signed [CW-1:0] a1_q [NUM_SECTIONS];
  logic signed [CW-1:0] a2_q [NUM_SECTIONS];
  logic signed [SW-1:0] x1_q [NUM_SECTIONS];
  logic signed [SW-1:0] x2_q [NUM_SECTIONS];
  logic signed [SW-1:0] y1_q [NUM_SECTIONS];
  logic signed [SW-1:0] y2_q [NUM_SECTIONS];

  // Configuration decode: section k lives at CONFIG_ADDR+k, control right after.
  logic [31:0]      cfg_off;
  logic             cfg_sec_hit, cfg_ctl_hit, cfg_hit;
  logic [SEC_W-1:0] cfg_sec;
  logic             unused_cfg;

  assign cfg_off     = config_addr - 32'(CONFIG_ADDR);
  assign cfg_sec_hit = cfg_off < 32'(NUM_SECTIONS);
  assign cfg_ctl_hit = cfg_off == 32'(NUM_SECTIONS);
  assign cfg_hit     = cfg_sec_hit | cfg_ctl_hit;
  assign cfg_sec     = cfg_off[SEC_W-1:0];
  assign unused_cfg  = ^config_data;

  logic ready, accept;
  assign ready         = resetn && (state_q == IDLE);
  assign accept        = s_axis.tvalid & ready;
  assign s_axis.tready = ready;
  assign m_axis.tvalid = (state_q == OUT);
  assign m_axis.tdata  = tdata_q;

  // Shared multiplier operand select; feedback taps are subtracted.
  logic signed [CW-1:0]     coef_sel;
  logic signed [SW-1:0]     data_sel;
  logic                     sub_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term, acc_mac, rounded, shifted;
  logic signed [SW-1:0]     y_new;
  logic                     sat_now;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    coef_sel = '0;
    data_sel = '0;
    sub_sel  = 1'b0;
    case (tap_q)
      3'd0: begin coef_sel = b0_q[sec_q]; data_sel = x_cur_q;     end
      3'd1: begin coef_sel = b1_q[sec_q]; data_sel = x1_q[sec_q]; end
      3'd2: begin coef_sel = b2_q[sec_q]; data_sel = x2_q[sec_q]; end
      3'd3: begin coef_sel = a1_q[sec_q]; data_sel = y1_q[sec_q]; sub_sel = 1'b1; end
      3'd4: begin coef_sel = a2_q[sec_q]; data_sel = y2_q[sec_q]; sub_sel = 1'b1; end
      default: ;
    endcase
  end

  assign prod    = PROD_W'(data_sel) * PROD_W'(coef_sel);
  assign term    = ACC_W'(prod);
  assign acc_mac = sub_sel ? (acc_q - term) : (acc_q + term);
  assign rounded = acc_q + ROUND_HALF;
  assign shifted = rounded >>> COEF_Q;

  always_comb begin
    y_new   = shifted[SW-1:0];
    sat_now = 1'b0;
    if (shifted > Y_MAX) begin
      y_new   = SAT_POS;
      sat_now = 1'b1;
    end else if (shifted < Y_MIN) begin
      y_new   = SAT_NEG;
      sat_now = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bypass_q ? OUT : COMPUTE;
      COMPUTE: begin
        if (cfg_hit)
          state_d = IDLE;
        else if (tap_q == TAP_UPDATE && sec_q == SEC_LAST)
          state_d = OUT;
      end
      OUT:     if (m_axis.tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: the coefficient and delay-line arrays are plain flops, so they are reset like any register.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      tap_q    <= '0;
      sec_q    <= '0;
      acc_q    <= '0;
      x_cur_q  <= '0;
      tdata_q  <= '0;
      bypass_q <= 1'b0;
      sat_flag <= 1'b0;
      for (int k = 0; k < NUM_SECTIONS; k++) begin
        b0_q[k] <= COEF_ONE;
        b1_q[k] <= '0;
        b2_q[k] <= '0;
        a1_q[k] <= '0;
        a2_q[k] <= '0;
        x1_q[k] <= '0;
        x2_q[k] <= '0;
        y1_q[k] <= '0;
        y2_q[k] <= '0;
      end
    end else begin
      if (state_q == IDLE && accept) begin
        tap_q   <= '0;
        sec_q   <= '0;
        acc_q   <= '0;
        x_cur_q <= s_axis.tdata;
        if (bypass_q) tdata_q <= s_axis.tdata;
      end

      // A config write during COMPUTE aborts the sample before any further update.
      if (state_q == COMPUTE && !cfg_hit) begin
        if (tap_q != TAP_UPDATE) begin
          acc_q <= acc_mac;
          tap_q <= tap_q + 3'd1;
        end else begin
          acc_q       <= '0;
          tap_q       <= '0;
          x_cur_q     <= y_new;
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= x_cur_q;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= y_new;
          if (sat_now) sat_flag <= 1'b1;
          if (sec_q == SEC_LAST) tdata_q <= y_new;
          else                   sec_q   <= sec_q + SEC_W'(1);
        end
      end

      if (cfg_sec_hit) begin
        b0_q[cfg_sec] <= config_data[0   +: CW];
        b1_q[cfg_sec] <= config_data[32  +: CW];
        b2_q[cfg_sec] <= config_data[64  +: CW];
        a1_q[cfg_sec] <= config_data[128 +: CW];
        a2_q[cfg_sec] <= config_data[160 +: CW];
        x1_q[cfg_sec] <= '0;
        x2_q[cfg_sec] <= '0;
        y1_q[cfg_sec] <= '0;
        y2_q[cfg_sec] <= '0;
      end

      if (cfg_ctl_hit) begin
        if (config_data[0]) sat_flag <= 1'b0;
        bypass_q <= config_data[1];
      end
    end
  end

endmodule

// File: tb/tb_axis_biquad_cascade_filter.sv
// Scoreboard bench for the biquad cascade: a wide-arithmetic reference model
// predicts every output, directed cases cover timing, saturation, bypass, abort.
module tb_axis_biquad_cascade_filter;

  localparam int SW   = 32;
  localparam int CW   = 32;
  localparam int Q    = 28;
  localparam int NS   = 4;
  localparam int BASE = 999;

  localparam logic signed [127:0] HALF  = 128'sd1 <<< (Q - 1);
  localparam logic signed [127:0] W_MAX = 128'sh7FFF_FFFF;
  localparam logic signed [127:0] W_MIN = -W_MAX - 128'sd1;

  logic         aclk = 1'b0;
  logic         resetn;
  logic [31:0]  config_addr;
  logic [511:0] config_data;
  logic         sat_flag;

  axis_biquad_cascade_filter_if #(.WIDTH(SW)) s_axis ();
  axis_biquad_cascade_filter_if #(.WIDTH(SW)) m_axis ();

  axis_biquad_cascade_filter #(
    .SIGNAL_WIDTH(SW), .COEF_WIDTH(CW), .COEF_Q(Q),
    .NUM_SECTIONS(NS), .CONFIG_ADDR(BASE)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .config_addr(config_addr), .config_data(config_data),
    .s_axis(s_axis), .m_axis(m_axis), .sat_flag(sat_flag)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic signed [31:0] mb0 [NS], mb1 [NS], mb2 [NS], ma1 [NS], ma2 [NS];
  logic signed [31:0] mx1 [NS], mx2 [NS], my1 [NS], my2 [NS];
  logic               m_sat, m_byp;
  logic [31:0]        exp_q [$];

  function automatic logic signed [127:0] wide(input logic signed [31:0] v);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      mb0[k] = 32'sd1 <<< Q;
      mb1[k] = 0; mb2[k] = 0; ma1[k] = 0; ma2[k] = 0;
      mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0;
    end
    m_sat = 1'b0;
    m_byp = 1'b0;
  endtask

  task automatic sec_step(input int k, input logic signed [31:0] x, output logic signed [31:0] y);
    logic signed [127:0] acc, r;
    acc = wide(mb0[k]) * wide(x) + wide(mb1[k]) * wide(mx1[k]) + wide(mb2[k]) * wide(mx2[k])
        - wide(ma1[k]) * wide(my1[k]) - wide(ma2[k]) * wide(my2[k]);
    r = (acc + HALF) >>> Q;
    if (r > W_MAX)      begin y = 32'sh7FFF_FFFF; m_sat = 1'b1; end
    else if (r < W_MIN) begin y = 32'sh8000_0000; m_sat = 1'b1; end
    else                y = r[31:0];
    mx2[k] = mx1[k]; mx1[k] = x;
    my2[k] = my1[k]; my1[k] = y;
  endtask

  task automatic model_run(input logic signed [31:0] x, output logic signed [31:0] y);
    logic signed [31:0] v;
    v = x;
    if (!m_byp)
      for (int k = 0; k < NS; k++) sec_step(k, v, v);
    y = v;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic cfg_sec(input int k, input logic signed [31:0] b0, b1, b2, a1, a2);
    config_addr          = 32'(BASE + k);
    config_data          = '0;
    config_data[31:0]    = b0;
    config_data[63:32]   = b1;
    config_data[95:64]   = b2;
    config_data[127:96]  = 32'hDEAD_BEEF;
    config_data[159:128] = a1;
    config_data[191:160] = a2;
    tick();
    config_addr = 32'h0;
    mb0[k] = b0; mb1[k] = b1; mb2[k] = b2; ma1[k] = a1; ma2[k] = a2;
    mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0;
  endtask

  task automatic cfg_ctl(input bit clr, input bit byp);
    config_addr    = 32'(BASE + NS);
    config_data    = '0;
    config_data[0] = clr;
    config_data[1] = byp;
    tick();
    config_addr = 32'h0;
    if (clr) m_sat = 1'b0;
    m_byp = byp;
  endtask

  // Drive one sample, push its prediction, then pop and compare at the output.
  task automatic send(input string tag, input logic signed [31:0] x, input int exp_lat, input bit stall);
    int n, good;
    logic signed [31:0] y;
    logic [31:0] e;
    n = 0;
    while (!s_axis.tready && n < 100) begin tick(); n++; end
    check({tag, "_in_ready"}, 32'(s_axis.tready), 32'd1);
    s_axis.tdata  = x;
    s_axis.tvalid = 1'b1;
    model_run(x, y);
    exp_q.push_back(y);
    m_axis.tready = !stall;
    tick();
    s_axis.tvalid = 1'b0;
    n = 1;
    while (!m_axis.tvalid && n < 300) begin tick(); n++; end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    e = exp_q.pop_front();
    if (stall) begin
      good = 0;
      for (int i = 0; i < 10; i++) begin
        if (m_axis.tvalid && m_axis.tdata == e && !s_axis.tready) good++;
        tick();
      end
      check({tag, "_stall_hold"}, 32'(good), 32'd10);
      m_axis.tready = 1'b1;
    end
    check({tag, "_tdata"}, m_axis.tdata, e);
    tick();
    check({tag, "_valid_drop"}, 32'(m_axis.tvalid), 32'd0);
    check({tag, "_back_idle"}, 32'(s_axis.tready), 32'd1);
    check({tag, "_sat"}, 32'(sat_flag), 32'(m_sat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [31:0] y;
    int hi;
    resetn        = 1'b0;
    config_addr   = 32'h0;
    config_data   = '0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    model_reset();
    repeat (3) tick();
    check("rst_in_ready", 32'(s_axis.tready), 32'd0);
    check("rst_out_valid", 32'(m_axis.tvalid), 32'd0);
    check("rst_out_data", m_axis.tdata, 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    resetn = 1'b1;
    #1;
    check("rst_release_ready", 32'(s_axis.tready), 32'd1);
    tick();

    // Default pass-through cascade.
    send("passthru", 32'sd1000, 6 * NS + 1, 1'b0);

    // FIR: b0 = b1 = 0.5.
    cfg_sec(0, 32'sd1 <<< 27, 32'sd1 <<< 27, 0, 0, 0);
    send("fir0", 32'sd1000, 6 * NS + 1, 1'b0);
    send("fir1", 32'sd2000, 6 * NS + 1, 1'b0);
    send("fir2", 32'sd0,    6 * NS + 1, 1'b0);

    // IIR: y = x + 0.5*y1.
    cfg_sec(0, 32'sd1 <<< 28, 0, 0, -(32'sd1 <<< 27), 0);
    send("iir0", 32'sd1024, 6 * NS + 1, 1'b0);
    send("iir1", 32'sd0,    6 * NS + 1, 1'b0);
    send("iir2", 32'sd0,    6 * NS + 1, 1'b0);

    // Abort after section 0 has updated: section 0 keeps its new state.
    s_axis.tdata  = 32'sd100;
    s_axis.tvalid = 1'b1;
    tick();
    s_axis.tvalid = 1'b0;
    repeat (8) tick();
    sec_step(0, 32'sd100, y);
    cfg_ctl(1'b0, 1'b0);
    check("abort_no_valid", 32'(m_axis.tvalid), 32'd0);
    check("abort_idle", 32'(s_axis.tready), 32'd1);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_axis.tvalid) hi++;
      tick();
    end
    check("abort_no_output", 32'(hi), 32'd0);
    send("after_abort", 32'sd0, 6 * NS + 1, 1'b0);

    // Output back-pressure.
    send("stall", 32'sd777, 6 * NS + 1, 1'b1);

    // Saturation both ways, ignored addresses, then sticky-flag clear.
    cfg_sec(0, 32'sd1 <<< 29, 0, 0, 0, 0);
    send("sat_pos", 32'sh7FFF_FFF0, 6 * NS + 1, 1'b0);
    send("sat_neg", -32'sh7FFF_FFF0, 6 * NS + 1, 1'b0);
    config_addr    = 32'(BASE + NS + 1);
    config_data    = '0;
    config_data[1:0] = 2'b11;
    tick();
    config_addr = 32'(BASE - 1);
    config_data = '0;
    tick();
    config_addr = 32'h0;
    check("bad_addr_sat_kept", 32'(sat_flag), 32'd1);
    send("bad_addr_coefs", 32'sd300, 6 * NS + 1, 1'b0);
    cfg_ctl(1'b1, 1'b0);
    check("sat_cleared", 32'(sat_flag), 32'd0);

    // Bypass does not disturb section state: y = x + x1 in section 0.
    cfg_sec(0, 32'sd1 <<< 28, 32'sd1 <<< 28, 0, 0, 0);
    send("pre_bypass", 32'sd7, 6 * NS + 1, 1'b0);
    cfg_ctl(1'b0, 1'b1);
    send("bypass", -32'sd5, 1, 1'b0);
    cfg_ctl(1'b0, 1'b0);
    send("post_bypass", 32'sd10, 6 * NS + 1, 1'b0);

    // Random stable sections and samples.
    for (int k = 0; k < NS; k++)
      cfg_sec(k, $signed($urandom_range(0, 32'h1000_0000)) - 32'sh0800_0000,
                 $signed($urandom_range(0, 32'h1000_0000)) - 32'sh0800_0000,
                 $signed($urandom_range(0, 32'h1000_0000)) - 32'sh0800_0000,
                 $signed($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000,
                 $signed($urandom_range(0, 32'h0200_0000)) - 32'sh0100_0000);
    for (int i = 0; i < 16; i++)
      send("random", $signed($urandom_range(0, 32'h0020_0000)) - 32'sh0010_0000, 6 * NS + 1, 1'b0);

    // Reset mid-COMPUTE, with a config write held during reset.
    s_axis.tdata  = 32'sd55;
    s_axis.tvalid = 1'b1;
    tick();
    s_axis.tvalid = 1'b0;
    repeat (5) tick();
    resetn            = 1'b0;
    config_addr       = 32'(BASE);
    config_data       = '0;
    config_data[31:0] = 32'sd1 <<< 29;
    tick();
    config_addr = 32'h0;
    model_reset();
    check("midrst_in_ready", 32'(s_axis.tready), 32'd0);
    check("midrst_out_valid", 32'(m_axis.tvalid), 32'd0);
    check("midrst_out_data", m_axis.tdata, 32'd0);
    resetn = 1'b1;
    #1;
    check("midrst_release_ready", 32'(s_axis.tready), 32'd1);
    tick();
    send("after_reset", 32'sd1000, 6 * NS + 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
